// File: rtl/esfa_trace_writer.sv
// esfa_trace_writer: packs accepted ESFA operations into 72-bit sequencer words on a BRAM write port.
// Define TRACE_WRITER_EXPECT_EN to delay each word RESULT_LATENCY cycles and attach the observed result.
module esfa_trace_writer #(
  parameter int DEPTH = 256,
  parameter int RESULT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_will_write,
  input  logic [7:0]  op_index,
  input  logic [7:0]  op_value,
  input  logic [7:0]  op_metadata,
  input  logic        op_is_metadata,
  input  logic [7:0]  op_selector,
  input  logic        res_bool,
  input  logic [7:0]  res_value,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [71:0] mem_din,
  output logic        busy,
  output logic        done,
  output logic [8:0]  count,
  output logic [7:0]  last_addr,
  output logic        overflow
);
`ifdef TRACE_WRITER_EXPECT_EN
  localparam int D = RESULT_LATENCY;
  logic [23:0] hi;
  assign hi = {res_value, 7'b0, res_bool, 7'b0, 1'b1};
`else
  localparam int D = 1;
  logic [23:0] hi;
  logic unused_res;
  assign hi = '0;
  assign unused_res = ^{res_bool, res_value, 1'(RESULT_LATENCY)};
`endif
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);
  typedef enum logic [1:0] {IDLE, RECORD, DRAIN, DONE} state_t;
  state_t state_d, state_q;
  logic [D-1:0] pv_q;
  logic [47:0] pw_q [D];
  logic [8:0] acc_d, acc_q, count_q;
  logic [7:0] ptr_q, mem_addr_q, last_q;
  logic [71:0] mem_din_q;
  logic ready_d, ready_q, we_q, busy_q, done_q, ovf_q, accept, clr, pipe_empty;
  assign accept = op_valid && ready_q;
  assign pipe_empty = ~|pv_q;
  assign clr = start && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? RECORD : IDLE;
      RECORD:  state_d = !finish ? RECORD : (pipe_empty && !accept) ? DONE : DRAIN;
      DRAIN:   state_d = pipe_empty ? DONE : DRAIN;
      DONE:    state_d = start ? RECORD : DONE;
      default: state_d = IDLE;
    endcase
    acc_d = clr ? 9'd0 : acc_q + 9'(accept);
    ready_d = state_d == RECORD && acc_d < DEPTH9;
  end
  // acc_q counts every accepted op (written or still in flight), so it alone gates op_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pv_q <= '0;
      acc_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      ptr_q <= '0;
      count_q <= '0;
      last_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      ready_q <= ready_d;
      busy_q <= state_d == RECORD || state_d == DRAIN;
      done_q <= state_d == DONE;
      pv_q <= D > 1 ? {pv_q, accept} : D'(accept);
      we_q <= pv_q[D-1];
      if (pv_q[D-1]) begin
        mem_addr_q <= ptr_q;
        mem_din_q <= {hi, pw_q[D-1]};
        ptr_q <= ptr_q + 8'd1;
      end
      if (we_q) begin
        count_q <= count_q + 9'd1;
        last_q <= mem_addr_q;
      end
      if (state_q == RECORD && op_valid && acc_q == DEPTH9) ovf_q <= 1'b1;
      if (clr) begin
        ptr_q <= '0;
        count_q <= '0;
        last_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    pw_q[0] <= {op_selector, 7'b0, op_is_metadata, op_metadata, op_value, op_index, 7'b0, op_will_write};
    for (int i = 1; i < D; i++) pw_q[i] <= pw_q[i-1];
  end
  assign op_ready = ready_q;
  assign mem_we = we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
  assign busy = busy_q;
  assign done = done_q;
  assign count = count_q;
  assign last_addr = last_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_esfa_trace_writer.sv
// tb_esfa_trace_writer: directed stimulus with a queue scoreboard checked by a write-port monitor.
module tb_esfa_trace_writer;
  localparam int DEP = 4;
  localparam int RL = 2;
`ifdef TRACE_WRITER_EXPECT_EN
  localparam int L = RL;
  localparam bit EXP = 1'b1;
`else
  localparam int L = 1;
  localparam bit EXP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, finish = 1'b0, op_valid = 1'b0;
  logic op_will_write = 1'b0, op_is_metadata = 1'b0, res_bool = 1'b0;
  logic [7:0] op_index = '0, op_value = '0, op_metadata = '0, op_selector = '0, res_value = '0;
  logic op_ready, mem_we, busy, done, overflow;
  logic [7:0] mem_addr, last_addr;
  logic [71:0] mem_din;
  logic [8:0] count;
  typedef struct {int cyc; logic [7:0] addr; logic [71:0] din;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0, acc = 0, last_n = 0;
  bit rec = 1'b0, fix_res = 1'b0;

  esfa_trace_writer #(.DEPTH(DEP), .RESULT_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .op_valid(op_valid), .op_ready(op_ready),
    .op_will_write(op_will_write), .op_index(op_index), .op_value(op_value), .op_metadata(op_metadata),
    .op_is_metadata(op_is_metadata), .op_selector(op_selector), .res_bool(res_bool), .res_value(res_value),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done), .count(count),
    .last_addr(last_addr), .overflow(overflow));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Result bus follows a cycle-derived pattern so every captured expectation differs
  always @(posedge clk) begin
    #1;
    res_bool = fix_res ? 1'b1 : cyc[0];
    res_value = fix_res ? 8'hA5 : 8'(cyc) ^ 8'h5A;
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [71:0] word(input logic ww, input logic [7:0] idx, input logic [7:0] val,
                                       input logic [7:0] meta, input logic ism, input logic [7:0] sel, input int n);
    logic [71:0] w;
    int s;
    w = '0;
    w[0] = ww;
    w[15:8] = idx;
    w[23:16] = val;
    w[31:24] = meta;
    w[32] = ism;
    w[47:40] = sel;
    s = n + L - 1;
    if (EXP) begin
      w[48] = 1'b1;
      w[56] = fix_res ? 1'b1 : s[0];
      w[71:64] = fix_res ? 8'hA5 : 8'(s) ^ 8'h5A;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got write addr %0h din %0h expected no write (cycle %0d)", mem_addr, mem_din, cyc);
      end else begin
        e = q.pop_front();
        chk("we_cycle", 72'(cyc), 72'(e.cyc));
        chk("mem_addr", 72'(mem_addr), 72'(e.addr));
        chk("mem_din", mem_din, e.din);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic ww, input logic [7:0] idx, input logic [7:0] val, input logic [7:0] meta,
                         input logic ism, input logic [7:0] sel, input bit fin, input bit push);
    bit er;
    op_will_write = ww; op_index = idx; op_value = val; op_metadata = meta;
    op_is_metadata = ism; op_selector = sel; op_valid = 1'b1; finish = fin;
    @(negedge clk);
    er = rec && acc < DEP;
    chk("op_ready", 72'(op_ready), 72'(er));
    tick();
    op_valid = 1'b0;
    finish = 1'b0;
    if (er) begin
      if (push) q.push_back('{cyc + L, 8'(acc), word(ww, idx, val, meta, ism, sel, cyc)});
      acc++;
      last_n = cyc;
    end
    if (fin) rec = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    rec = 1'b1;
    acc = 0;
    last_n = 0;
  endtask

  task automatic finish_and_wait(input string name);
    int f, ex;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    rec = 1'b0;
    f = cyc;
    ex = (last_n + L + 1 > f) ? last_n + L + 1 : f;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(name, 72'(cyc), 72'(ex));
  endtask

  task automatic wait_done_after(input string name, input int ex);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(name, 72'(cyc), 72'(ex));
  endtask

  task automatic chk_reset_vals();
    @(negedge clk);
    chk("rst_op_ready", 72'(op_ready), 72'(0));
    chk("rst_mem_we", 72'(mem_we), 72'(0));
    chk("rst_mem_addr", 72'(mem_addr), 72'(0));
    chk("rst_mem_din", mem_din, 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_count", 72'(count), 72'(0));
    chk("rst_last_addr", 72'(last_addr), 72'(0));
    chk("rst_overflow", 72'(overflow), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();
    // three back-to-back ops recorded to addresses 0..2
    do_start();
    send_op(1'b1, 8'd1, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    send_op(1'b1, 8'd2, 8'h20, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    send_op(1'b1, 8'd3, 8'h30, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    finish_and_wait("t1_done_cycle");
    chk("t1_count", 72'(count), 72'(3));
    chk("t1_last_addr", 72'(last_addr), 72'(2));
    chk("t1_busy", 72'(busy), 72'(0));
    // hand-computed word with a fixed result pattern
    fix_res = 1'b1;
    do_start();
    send_op(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0);
    q.push_back('{last_n + L, 8'h00, EXP ? 72'hA5_01_01_05_00_00_00_00_00 : 72'h00_00_00_05_00_00_00_00_00});
    finish_and_wait("t2_done_cycle");
    fix_res = 1'b0;
    chk("t2_count", 72'(count), 72'(1));
    // fill to DEPTH and keep pushing
    do_start();
    for (int i = 0; i < 6; i++)
      send_op(1'(i), 8'(8'h40 + i), 8'(i * 3), 8'(8'h11 * i), 1'(i >> 1), 8'(8'hC0 + i), 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_overflow", 72'(overflow), 72'(1));
    chk("t3_op_ready", 72'(op_ready), 72'(0));
    finish_and_wait("t3_done_cycle");
    chk("t3_count", 72'(count), 72'(4));
    chk("t3_last_addr", 72'(last_addr), 72'(3));
    chk("t3_overflow_sticky", 72'(overflow), 72'(1));
    // empty recording, overflow cleared on restart
    do_start();
    @(negedge clk);
    chk("t6_overflow_clr", 72'(overflow), 72'(0));
    chk("t6_busy", 72'(busy), 72'(1));
    chk("t6_op_ready", 72'(op_ready), 72'(1));
    finish_and_wait("t6_done_cycle");
    chk("t6_count", 72'(count), 72'(0));
    chk("t6_last_addr", 72'(last_addr), 72'(0));
    // finish in the same cycle as an acceptance
    do_start();
    send_op(1'b1, 8'd7, 8'h77, 8'h3C, 1'b1, 8'h9A, 1'b1, 1'b1);
    wait_done_after("t4_done_cycle", last_n + L + 1);
    chk("t4_count", 72'(count), 72'(1));
    // reset with two ops in flight
    do_start();
    send_op(1'b1, 8'd8, 8'h81, 8'h00, 1'b0, 8'h01, 1'b0, L == 1);
    send_op(1'b1, 8'd9, 8'h91, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0);
    rst = 1'b1;
    rec = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals();
    repeat (5) tick();
    chk("t5_count", 72'(count), 72'(0));
    chk("queue_empty", 72'(q.size()), 72'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/esfa_trace_writer.md
# esfa_trace_writer

Records the operation stream applied to the ESFA design into the 72-bit instruction-word format consumed by the ROM-driven test sequencer, writing one word per operation into a block-RAM write port. It sits beside the ESFA core during live or scripted runs, capturing each applied operation and, optionally, the core's observed result as the expected value. Captured traces can be replayed later as self-checking programs. On completion it reports the highest written instruction index.

## Interface
- `DEPTH`, 256: memory words; power of two, at most 256.
- `RESULT_LATENCY`, 1: cycles from operation acceptance to a valid `res_bool`/`res_value`; range 1–7.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: begin a new recording; clears the write pointer.
- `finish` input 1: end the recording after in-flight operations drain.
- `op_valid` input 1: operation present.
- `op_ready` output 1: operation can be accepted.
- `op_will_write` input 1: write flag (bit 0).
- `op_index` input 8: new_index field (bits 15:8).
- `op_value` input 8: new_value field (bits 23:16).
- `op_metadata` input 8: metadata field (bits 31:24).
- `op_is_metadata` input 1: isMetadata flag (bit 32).
- `op_selector` input 8: selector field (bits 47:40).
- `res_bool` input 1: ESFA resultBool, sampled `RESULT_LATENCY` cycles after acceptance.
- `res_value` input 8: ESFA resultValue, sampled with `res_bool`.
- `mem_we` output 1: one-cycle write strobe.
- `mem_addr` output 8: write address.
- `mem_din` output 72: packed word.
- `busy` output 1: in RECORD or DRAIN.
- `done` output 1: in DONE.
- `count` output 9: words written this recording.
- `last_addr` output 8: highest written index, which is `count-1`; 0 when `count`=0.
- `overflow` output 1: sticky; set when `op_valid` is high while full in RECORD.

## Operation
- Word layout:
  - bit 0: will_write
  - 15:8: index
  - 23:16: value
  - 31:24: metadata
  - 32: is_metadata
  - 47:40: selector
  - 48: assert
  - 56: expected bool
  - 71:64: expected value
  - All other bits: 0.
- States:
  - IDLE → RECORD on `start`. `finish` is ignored in IDLE.
  - RECORD → DRAIN on `finish`.
  - DRAIN → DONE when the delay pipeline is empty.
  - DONE → RECORD on `start`.
  - Entering RECORD clears `count`, the write pointer, and `overflow`.
- Acceptance: `op_valid && op_ready`. `op_ready` = RECORD && (`count` + in-flight) < `DEPTH`.
- Accepted operations enter a `RESULT_LATENCY`-deep shift pipeline. At the pipeline exit:
  - The word is packed and `mem_we` pulses.
  - `mem_addr` = write pointer.
  - The pointer and `count` then increment.
- Writes occur in acceptance order. Back-to-back acceptance gives one write per cycle.
- An operation accepted in the same cycle as `finish` is recorded.
- Once full, further operations are refused. If `op_valid` is high while full, `overflow` is set. Counting of refused operations saturates and the pointer does not wrap.
- `start` in RECORD or DRAIN is ignored.

## Timing
- Reset values:
  - state IDLE
  - `op_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0
  - `busy`=0, `done`=0, `count`=0, `last_addr`=0, `overflow`=0
  - pipeline cleared
- Reset mid-recording drops in-flight operations; no further `mem_we`. Already-written memory contents are unspecified.
- `op_ready` is high the cycle after `start`.
- With `TRACE_WRITER_EXPECT_EN`: `mem_we` is asserted exactly `RESULT_LATENCY` cycles after acceptance. `res_*` are sampled in the acceptance cycle + `RESULT_LATENCY`.
- Without `TRACE_WRITER_EXPECT_EN`: `mem_we` is asserted 1 cycle after acceptance.
- `done` rises the cycle after the last drain write. If nothing is in flight, it rises the cycle after `finish`.
- `count`/`last_addr` update the cycle after each `mem_we`.
- Outputs are registered.

## Configuration
- `TRACE_WRITER_EXPECT_EN` defined:
  - Bit 48 = 1.
  - Bit 56 = sampled `res_bool`; 71:64 = sampled `res_value`.
  - Pipeline depth is `RESULT_LATENCY`.
- `TRACE_WRITER_EXPECT_EN` undefined:
  - Bits 48, 56, and 71:64 = 0.
  - `res_*` are unused.
  - Pipeline depth is fixed at 1 and `RESULT_LATENCY` is ignored.

## Test plan
- Reset, then `start`; 3 back-to-back ops (idx 1/2/3, value 0x10/0x20/0x30, will_write=1); then `finish` → writes to addresses 0,1,2 on consecutive cycles, bits 15:8 = 1/2/3, `done`=1, `count`=3, `last_addr`=2.
- EXPECT_EN with `RESULT_LATENCY`=2: op with selector 0x05; `res_bool`=1, `res_value`=0xA5 presented 2 cycles later → word 0x A5_01_01_05_00_00_00_00_00 with the layout fields set. `mem_we` is asserted 2 cycles after acceptance.
- `DEPTH`=4: drive 6 consecutive valid ops → 4 writes, `op_ready` low after the 4th acceptance, `overflow`=1, `count`=4, no wrap to address 0.
- `finish` in the same cycle as an acceptance → that op is written; `done` follows its write by 1 cycle.
- Reset asserted with 2 ops in flight → no `mem_we` after reset; all outputs at reset values.
- `finish` with no ops → `done`=1 the next cycle, `count`=0, `last_addr`=0; `start` again returns to RECORD with `overflow` cleared.
